// File: rtl/io_port_peripheral.sv
// Loopback peripheral for the CPU I/O ports: captures out-port writes into a FIFO and
// replays them to the in-port with a strobe. Define IO_RD_RETRY_EN to re-strobe unconsumed words.
module io_port_peripheral #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int RETRY_CYCLES = 16
) (
    input  logic                          Clock,
    input  logic                          clear,
    input  logic                          out_wr,
    input  logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          in_rd,
    output logic [DATA_WIDTH-1:0]         input_data,
    output logic                          strobe,
    output logic                          pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRESENT, STROBE, WAIT_RD} state_t;

    state_t                state, state_d;
    logic                  out_wr_q, in_rd_q;
    logic                  wr_rise, rd_rise;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  full, push, pop;
    logic                  strobe_d, pending_d;

`ifdef IO_RD_RETRY_EN
    localparam int RW = $clog2(RETRY_CYCLES + 1);
    logic [RW-1:0] retry_cnt, retry_cnt_d;
`endif

    assign wr_rise = out_wr & ~out_wr_q;
    assign rd_rise = in_rd & ~in_rd_q;
    assign full    = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign push    = wr_rise & ~full;

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        strobe_d  = 1'b0;
        pending_d = pending;
`ifdef IO_RD_RETRY_EN
        retry_cnt_d = retry_cnt;
`endif
        case (state)
            IDLE: begin
                if (fifo_count != '0) state_d = PRESENT;
            end
            PRESENT: begin
                pop      = 1'b1;
                strobe_d = 1'b1;
                state_d  = STROBE;
`ifdef IO_RD_RETRY_EN
                retry_cnt_d = '0;
`endif
            end
            STROBE: begin
                pending_d = 1'b1;
                state_d   = WAIT_RD;
`ifdef IO_RD_RETRY_EN
                retry_cnt_d = retry_cnt + 1'b1;
`endif
            end
            WAIT_RD: begin
                if (rd_rise) begin
                    pending_d = 1'b0;
                    state_d   = IDLE;
                end
`ifdef IO_RD_RETRY_EN
                // Counter restarts on each strobe edge, so pulses are RETRY_CYCLES apart.
                else if (retry_cnt == RW'(RETRY_CYCLES - 1)) begin
                    strobe_d    = 1'b1;
                    retry_cnt_d = '0;
                end else begin
                    retry_cnt_d = retry_cnt + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            state      <= IDLE;
            out_wr_q   <= 1'b0;
            in_rd_q    <= 1'b0;
            input_data <= '0;
            strobe     <= 1'b0;
            pending    <= 1'b0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
`ifdef IO_RD_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            state    <= state_d;
            out_wr_q <= out_wr;
            in_rd_q  <= in_rd;
            strobe   <= strobe_d;
            pending  <= pending_d;
`ifdef IO_RD_RETRY_EN
            retry_cnt <= retry_cnt_d;
`endif
            if (pop) begin
                input_data <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (wr_rise && full) overflow <= 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!clear && push) mem[wr_ptr] <= out_data;
    end

endmodule

// File: tb/tb_io_port_peripheral.sv
// Scoreboard bench for io_port_peripheral: stimulus queues expected words, a negedge
// monitor checks every strobe; directed checks cover timing, overflow, push/pop and reset.
module tb_io_port_peripheral;

    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int RC  = 16;

    logic                 Clock, clear, out_wr, in_rd;
    logic [DW-1:0]        out_data, input_data;
    logic                 strobe, pending, overflow;
    logic [$clog2(DEP):0] fifo_count;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_strobe_cyc = 0;
    int          retries = 0;
    logic        prev_strobe = 1'b0;
    logic [DW-1:0] last_word = '0;
    logic [DW-1:0] exp_q[$];

    io_port_peripheral #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .RETRY_CYCLES(RC)) dut (
        .Clock(Clock), .clear(clear), .out_wr(out_wr), .out_data(out_data), .in_rd(in_rd),
        .input_data(input_data), .strobe(strobe), .pending(pending),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a fresh strobe (pending still low) must match the next scoreboard entry.
    always @(negedge Clock) begin
        if (!clear && strobe) begin
            check("strobe_width", {63'd0, prev_strobe}, 64'd0);
            if (pending) begin
`ifdef IO_RD_RETRY_EN
                check("retry_data", input_data, last_word);
                check("retry_period", cyc - last_strobe_cyc, RC);
                retries++;
`else
                check("restrobe_pending", pending, 0);
`endif
            end else if (exp_q.size() == 0) begin
                check("unexpected_strobe", strobe, 0);
            end else begin
                last_word = exp_q.pop_front();
                check("strobe_data", input_data, last_word);
            end
            last_strobe_cyc = cyc;
        end
        prev_strobe = strobe;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clock);
    endtask

    task automatic write_word(input logic [DW-1:0] d, input bit expect_capture);
        out_data = d;
        out_wr   = 1'b1;
        if (expect_capture) exp_q.push_back(d);
        tick();
        out_wr = 1'b0;
        tick();
    endtask

    task automatic consume();
        in_rd = 1'b1;
        tick();
        in_rd = 1'b0;
    endtask

    task automatic wait_pending(input logic val, input int budget);
        int n = 0;
        while (pending !== val && n < budget) begin
            tick();
            n++;
        end
        if (pending !== val) check("wait_pending_timeout", pending, val);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1; out_wr = 1'b1; in_rd = 1'b0; out_data = 32'hDEAD_BEEF;

        // Reset, with out_wr held high throughout
        tick(2);
        check("rst_input_data", input_data, 0);
        check("rst_strobe", strobe, 0);
        check("rst_pending", pending, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        out_wr = 1'b0; clear = 1'b0;
        tick(4);
        check("rst_no_capture", fifo_count, 0);

        // Single transfer with exact latency; out_wr held two cycles
        out_data = 32'h0000_ABBA; out_wr = 1'b1; exp_q.push_back(32'h0000_ABBA);
        tick();                                   // edge N
        check("single_count_N", fifo_count, 1);
        tick();                                   // edge N+1
        out_wr = 1'b0;
        check("single_strobe_N1", strobe, 0);
        check("single_count_N1", fifo_count, 1);
        tick();                                   // edge N+2
        check("single_strobe_N2", strobe, 1);
        check("single_count_N2", fifo_count, 0);
        check("single_pending_N2", pending, 0);
        tick();                                   // edge N+3
        check("single_strobe_N3", strobe, 0);
        check("single_pending_N3", pending, 1);
        check("single_data", input_data, 32'h0000_ABBA);
        tick(3);
        check("single_hold_pending", pending, 1);
        consume();
        check("single_consumed", pending, 0);
        check("single_count_end", fifo_count, 0);

        // Ordering: each word only after the preceding consume
        write_word(32'h11, 1);
        write_word(32'h22, 1);
        write_word(32'h33, 1);
        for (int i = 0; i < 3; i++) begin
            wait_pending(1'b1, 30);
            tick(3);
            check("order_waits", pending, 1);
            consume();
        end
        tick(8);
        check("order_idle_pending", pending, 0);
        check("order_idle_count", fifo_count, 0);

        // Overflow: no consumption; first word parks in WAIT_RD, four fill the FIFO
        write_word(32'hA1, 1);
        write_word(32'hA2, 1);
        write_word(32'hA3, 1);
        write_word(32'hA4, 1);
        write_word(32'hA5, 1);
        check("ovf_full_count", fifo_count, 4);
        check("ovf_not_yet", overflow, 0);
        write_word(32'hA6, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count_held", fifo_count, 4);
        for (int i = 0; i < 5; i++) begin
            wait_pending(1'b1, 40);
            consume();
        end
        tick(10);
        check("ovf_drained", fifo_count, 0);
        check("ovf_drain_pending", pending, 0);
        check("ovf_sticky", overflow, 1);
        do_clear();
        check("ovf_cleared", overflow, 0);

        // Simultaneous push/pop: capture lands on the PRESENT edge with two words queued
        write_word(32'hB0, 1);
        wait_pending(1'b1, 30);
        write_word(32'hB1, 1);
        write_word(32'hB2, 1);
        check("pp_queued", fifo_count, 2);
        in_rd = 1'b1;
        tick();                                   // consume edge -> IDLE
        in_rd = 1'b0;
        check("pp_consumed", pending, 0);
        tick();                                   // IDLE -> PRESENT
        out_data = 32'hB3; out_wr = 1'b1; exp_q.push_back(32'hB3);
        tick();                                   // PRESENT edge: push + pop
        out_wr = 1'b0;
        check("pp_count_stays", fifo_count, 2);
        check("pp_strobe", strobe, 1);
        for (int i = 0; i < 3; i++) begin
            wait_pending(1'b1, 30);
            consume();
        end
        tick(8);
        check("pp_drained", fifo_count, 0);

        // Clear while waiting: queued word discarded, no further strobe
        write_word(32'hC0, 1);
        wait_pending(1'b1, 30);
        write_word(32'hC1, 0);
        do_clear();
        check("clr_pending", pending, 0);
        check("clr_count", fifo_count, 0);
        tick(40);
        check("clr_still_idle", pending, 0);

`ifdef IO_RD_RETRY_EN
        // Retry: strobe re-pulses every RC cycles until consumed
        retries = 0;
        write_word(32'hE5, 1);
        wait_pending(1'b1, 30);
        for (int n = 0; n < 80 && retries < 2; n++) tick();
        check("retry_count", retries, 2);
        check("retry_pending", pending, 1);
        consume();
        check("retry_consumed", pending, 0);
        tick(40);
        check("retry_stopped", retries, 2);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
